// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. It owns the PC, issues word reads to
// instruction memory and buffers {pc, inst} pairs in a small FIFO for decode.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   o_imem_req/o_imem_addr             fetch request and word address
//   i_imem_ack/i_imem_rdata            request accepted, data valid this cycle
//   o_valid/i_ready/o_inst/o_pc        head of buffer to decode (NOP when empty)
//   i_redirect/i_redirect_pc           restart fetch at a new target
//   o_misalign                         sticky bad-target flag
// Optional feature: define IFU_MISALIGN_CHECK_EN to make a redirect to a
// non-word-aligned target set o_misalign and stop fetching until reset.
// Without it o_misalign is 0 and the target's low bits are cleared.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misalign
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_drop_pc;
    logic [31:0]   r_pc_mem   [FIFO_DEPTH];
    logic [31:0]   r_inst_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_req;
    logic          w_valid;
    logic          w_busy;
    logic          w_push;
    logic          w_pop;
    logic          w_stop;
    logic [31:0]   w_tgt;

    assign w_tgt   = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_valid = (r_count != '0);
    // Request on the bus that memory has not yet answered; must be completed.
    assign w_busy  = w_req & ~i_imem_ack;
    assign w_push  = w_req & i_imem_ack & ~i_redirect & (r_state != S_DROP);
    assign w_pop   = w_valid & i_ready & ~i_redirect;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_bad;

    assign w_bad = i_redirect & (i_redirect_pc[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_misalign <= 1'b0;
        end else if (w_bad) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_stop = r_misalign;
`else
    assign w_stop = 1'b0;
`endif

    assign o_misalign = w_stop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (i_redirect) begin
            w_state_nx = w_busy ? S_DROP : S_REQ;
        end else begin
            unique case (r_state)
                S_REQ:          if (w_busy) w_state_nx = S_WAIT;
                S_WAIT, S_DROP: if (i_imem_ack) w_state_nx = S_REQ;
                default:        w_state_nx = S_REQ;
            endcase
        end
    end

    // In S_REQ no request is pending, so count alone decides free space.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            S_REQ:          w_req = (r_count < DEPTH_C) & ~w_stop;
            S_WAIT, S_DROP: w_req = 1'b1;
            default:        w_req = 1'b0;
        endcase
        if (i_reset) begin
            w_req = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC_A;
            r_drop_pc  <= RESET_PC_A;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            if (w_busy) begin
                r_drop_pc <= w_tgt;
            end else begin
                r_fetch_pc <= w_tgt;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else if (r_state == S_DROP && i_imem_ack) begin
                r_fetch_pc <= r_drop_pc;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (~w_push & w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= i_imem_rdata;
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_valid     = w_valid;
    assign o_inst      = w_valid ? r_inst_mem[r_rd_ptr] : NOP;
    assign o_pc        = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a latency-programmable
// memory and an in-order delivery model checked on every cycle.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_misalign;

    int total = 0;
    int bad = 0;
    int lat = 0;
    int wcnt = 0;

    ifetch_unit dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .o_imem_req(o_imem_req),
        .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack),
        .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_inst(o_inst),
        .o_pc(o_pc),
        .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h00A5_0000) | 32'h3;
    endfunction

    // Memory answers a request after lat idle cycles (lat=0: same cycle).
    assign i_imem_ack   = o_imem_req && (wcnt >= lat);
    assign i_imem_rdata = i_imem_ack ? mem_word(o_imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (i_reset || !o_imem_req || i_imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the head must always be the next PC in program order.
    logic [31:0] exp_pc = 32'h0;
    logic        exp_mis = 1'b0;
    logic        prev_rst = 1'b1;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_valid", 32'(o_valid), 32'h0);
            chk("rst_inst", o_inst, 32'h13);
            chk("rst_pc", o_pc, 32'h0);
            chk("rst_mis", 32'(o_misalign), 32'h0);
            if (i_reset) chk("rst_req", 32'(o_imem_req), 32'h0);
        end else begin
            if (o_valid) begin
                chk("m_pc", o_pc, exp_pc);
                chk("m_inst", o_inst, mem_word(exp_pc));
            end else begin
                chk("m_nop", o_inst, 32'h13);
                chk("m_pc0", o_pc, 32'h0);
            end
            chk("m_align", 32'(o_imem_addr[1:0]), 32'h0);
            chk("m_mis", 32'(o_misalign), 32'(exp_mis));
        end
        if (!prev_rst && !i_reset && prev_pend) begin
            chk("hold_req", 32'(o_imem_req), 32'h1);
            chk("hold_addr", o_imem_addr, prev_addr);
        end
        if (i_reset) begin
            exp_pc  = 32'h0;
            exp_mis = 1'b0;
        end else if (i_redirect) begin
            exp_pc = i_redirect_pc & 32'hFFFF_FFFC;
`ifdef IFU_MISALIGN_CHECK_EN
            if (i_redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
`endif
        end else if (o_valid && i_ready) begin
            exp_pc = exp_pc + 32'd4;
        end
        prev_rst  = i_reset;
        prev_pend = o_imem_req && !i_imem_ack;
        prev_addr = o_imem_addr;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!o_valid && n < maxc) begin
            cyc();
            n++;
        end
        chk("wait_valid", 32'(o_valid), 32'h1);
    endtask

    task automatic wait_pend(input int maxc);
        int n = 0;
        while (!(o_imem_req && !i_imem_ack) && n < maxc) begin
            cyc();
            n++;
        end
        chk("wait_pend", 32'(o_imem_req && !i_imem_ack), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // 1: streaming at one instruction per cycle
        cyc(3);
        chk("t1_rvalid", 32'(o_valid), 32'h0);
        chk("t1_rinst", o_inst, 32'h13);
        chk("t1_rreq", 32'(o_imem_req), 32'h0);
        i_reset = 1'b0;
        #1;
        chk("t1_req", 32'(o_imem_req), 32'h1);
        chk("t1_addr", o_imem_addr, 32'h0);
        cyc();
        chk("t1_v0", 32'(o_valid), 32'h1);
        chk("t1_pc0", o_pc, 32'h0);
        cyc();
        chk("t1_pc4", o_pc, 32'h4);
        cyc();
        chk("t1_pc8", o_pc, 32'h8);

        // 2: stalled consumer fills exactly two entries
        i_reset = 1'b1;
        i_ready = 1'b0;
        cyc(2);
        i_reset = 1'b0;
        cyc();
        chk("t2_req1", 32'(o_imem_req), 32'h1);
        chk("t2_pc0", o_pc, 32'h0);
        cyc();
        chk("t2_req0", 32'(o_imem_req), 32'h0);
        cyc(3);
        chk("t2_full", 32'(o_imem_req), 32'h0);
        chk("t2_head", o_pc, 32'h0);
        i_ready = 1'b1;
        cyc();
        chk("t2_pc4", o_pc, 32'h4);
        cyc();
        chk("t2_pc8", o_pc, 32'h8);
        cyc();
        chk("t2_pcc", o_pc, 32'hC);

        // 4: redirect collides with an ack
        i_ready = 1'b0;
        cyc(4);
        chk("t4_full", 32'(o_imem_req), 32'h0);
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h80;
        #1;
        chk("t4_ack", 32'(i_imem_ack), 32'h1);
        cyc();
        i_redirect = 1'b0;
        chk("t4_flush", 32'(o_valid), 32'h0);
        cyc();
        chk("t4_v", 32'(o_valid), 32'h1);
        chk("t4_pc", o_pc, 32'h80);
        i_ready = 1'b1;

        // 3: redirect while a slow fetch is in flight
        i_reset = 1'b1;
        lat = 3;
        cyc(2);
        i_reset = 1'b0;
        begin
            int n = 0;
            while (!(o_imem_req && o_imem_addr == 32'h10 && !i_imem_ack)
                   && n < 100) begin
                cyc();
                n++;
            end
        end
        chk("t3_at10", o_imem_addr, 32'h10);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h200;
        cyc();
        i_redirect = 1'b0;
        chk("t3_drop", o_imem_addr, 32'h10);
        wait_valid(50);
        chk("t3_pc", o_pc, 32'h200);

        // 7: back-to-back redirects, newest target wins
        wait_pend(50);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h300;
        cyc();
        i_redirect_pc = 32'h400;
        cyc();
        i_redirect = 1'b0;
        wait_valid(50);
        chk("t7_pc", o_pc, 32'h400);

        // 5: reset while waiting on memory
        begin
            int n = 0;
            while (!(o_imem_req && wcnt == 1) && n < 50) begin
                cyc();
                n++;
            end
        end
        chk("t5_wait", 32'(i_imem_ack), 32'h0);
        i_reset = 1'b1;
        cyc(2);
        chk("t5_v", 32'(o_valid), 32'h0);
        chk("t5_inst", o_inst, 32'h13);
        chk("t5_pc0", o_pc, 32'h0);
        chk("t5_req", 32'(o_imem_req), 32'h0);
        i_reset = 1'b0;
        lat = 0;
        wait_valid(10);
        chk("t5_pc", o_pc, 32'h0);
        cyc();
        chk("t5_pc4", o_pc, 32'h4);

        // 6: misaligned redirect target
        i_redirect = 1'b1;
        i_redirect_pc = 32'h102;
        cyc();
        i_redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        chk("t6_mis", 32'(o_misalign), 32'h1);
        cyc(3);
        chk("t6_req", 32'(o_imem_req), 32'h0);
        chk("t6_v", 32'(o_valid), 32'h0);
`else
        chk("t6_mis", 32'(o_misalign), 32'h0);
        wait_valid(10);
        chk("t6_pc", o_pc, 32'h100);
        cyc();
        chk("t6_pc4", o_pc, 32'h104);
`endif
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
